// File: rtl/leaf_pkg.sv
// leaf_pkg: packet field layout and remote buffer depth shared by the leaf interface
package leaf_pkg;
  localparam int LEAF_LSB = 43;
  localparam int PORT_LSB = 39;
  localparam int ADDR_LSB = 32;
  localparam int BUF_DEPTH = 128;
  typedef struct packed {
    logic valid;
    logic [4:0] leaf;
    logic [3:0] port;
    logic [6:0] addr;
    logic [31:0] payload;
  } packet_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant; pointer moves past the winner when advance is set
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic [PW-1:0] ptr, gidx;
  always_comb begin
    grant = '0;
    gidx = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NUM_REQ]) begin
        grant = '0;
        grant[(int'(ptr) + k) % NUM_REQ] = 1'b1;
        gidx = PW'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) ptr <= '0;
    else if (advance) ptr <= (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
  end
endmodule

// File: rtl/leaf_stream2packet.sv
// leaf_stream2packet: arbitrates user streams into BFT packets with per-stream credits
// Credit counters are built only when LEAF_TX_CREDIT_EN is defined.
module leaf_stream2packet
  import leaf_pkg::*;
#(
  parameter int PACKET_BITS = 49,
  parameter int PAYLOAD_BITS = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int NUM_OUT_PORTS = 3,
  parameter int NUM_BRAM_ADDR_BITS = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  ap_start,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
  input  logic                                  cfg_wr_en,
  input  logic [NUM_PORT_BITS-1:0]              cfg_stream,
  input  logic [NUM_LEAF_BITS-1:0]              cfg_leaf,
  input  logic [NUM_PORT_BITS-1:0]              cfg_port,
  input  logic                                  credit_vld,
  input  logic [NUM_PORT_BITS-1:0]              credit_stream,
  input  logic                                  resend,
  output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft
);
  logic started;
  logic [NUM_OUT_PORTS-1:0] cfg_valid, cfg_hit, credit_ok, elig, grant;
  logic [NUM_LEAF_BITS-1:0] leaf [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] port [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr [NUM_OUT_PORTS];
  logic [PACKET_BITS-1:0] pkt;
  always_comb
    for (int i = 0; i < NUM_OUT_PORTS; i++) cfg_hit[i] = cfg_wr_en && cfg_stream == NUM_PORT_BITS'(i);
  assign elig = {NUM_OUT_PORTS{started & ~resend}} & vld_user2interface & cfg_valid & credit_ok;
  assign ack_interface2user = grant;
  rr_arbiter #(.NUM_REQ(NUM_OUT_PORTS)) u_arb (
    .clk(clk),
    .reset(reset),
    .req(elig),
    .advance(|grant),
    .grant(grant)
  );
  always_ff @(posedge clk) begin
    started <= reset ? 1'b0 : started | ap_start;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (reset) begin
        cfg_valid[i] <= 1'b0;
        leaf[i] <= '0;
        port[i] <= '0;
        addr[i] <= '0;
      end else if (cfg_hit[i]) begin
        cfg_valid[i] <= 1'b1;
        leaf[i] <= cfg_leaf;
        port[i] <= cfg_port;
        addr[i] <= '0;
      end else if (grant[i]) addr[i] <= addr[i] + 1'b1;
    end
  end
`ifdef LEAF_TX_CREDIT_EN
  localparam int CW = NUM_BRAM_ADDR_BITS + 1;
  logic [CW-1:0] credit [NUM_OUT_PORTS];
  logic [CW:0] credit_sum [NUM_OUT_PORTS];
  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      credit_ok[i] = credit[i] != '0;
      credit_sum[i] = (CW+1)'(credit[i]) - (CW+1)'(grant[i])
        + ((credit_vld && credit_stream == NUM_PORT_BITS'(i)) ? (CW+1)'(FREESPACE_UPDATE_SIZE) : '0);
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (reset || cfg_hit[i]) credit[i] <= CW'(BUF_DEPTH);
      else credit[i] <= (credit_sum[i] > (CW+1)'(BUF_DEPTH)) ? CW'(BUF_DEPTH) : credit_sum[i][CW-1:0];
    end
  end
`else
  logic unused_credit;
  assign credit_ok = '1;
  assign unused_credit = ^{credit_vld, credit_stream} ^ (FREESPACE_UPDATE_SIZE != 0) ^ (NUM_BRAM_ADDR_BITS != 0);
`endif
  always_comb begin
    pkt = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (grant[i]) begin
        pkt[PACKET_BITS-1] = 1'b1;
        pkt[LEAF_LSB +: NUM_LEAF_BITS] = leaf[i];
        pkt[PORT_LSB +: NUM_PORT_BITS] = port[i];
        pkt[ADDR_LSB +: NUM_ADDR_BITS] = addr[i];
        pkt[0 +: PAYLOAD_BITS] = din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) dout_leaf_interface2bft <= '0;
    else if (!resend) dout_leaf_interface2bft <= pkt;
  end
endmodule

// File: tb/tb_leaf_stream2packet.sv
// tb_leaf_stream2packet: directed table plus corner sequences for leaf_stream2packet
module tb_leaf_stream2packet;
  import leaf_pkg::*;
  logic clk = 0, reset = 1, ap_start = 0, cfg_wr_en = 0, credit_vld = 0, resend = 0;
  logic [95:0] din = '0;
  logic [2:0] vld = '0, ack;
  logic [3:0] cfg_stream = '0, cfg_port = '0, credit_stream = '0;
  logic [4:0] cfg_leaf = '0;
  logic [48:0] dout;
  int checks = 0, errors = 0;
  typedef struct {
    logic [2:0] vld;
    logic resend;
    logic [2:0] ack;
    logic [48:0] dout;
  } vec_t;
  vec_t tab [15];
  always #5 clk = ~clk;
  leaf_stream2packet dut (
    .clk(clk), .reset(reset), .ap_start(ap_start),
    .din_leaf_user2interface(din), .vld_user2interface(vld), .ack_interface2user(ack),
    .cfg_wr_en(cfg_wr_en), .cfg_stream(cfg_stream), .cfg_leaf(cfg_leaf), .cfg_port(cfg_port),
    .credit_vld(credit_vld), .credit_stream(credit_stream), .resend(resend),
    .dout_leaf_interface2bft(dout)
  );
  task automatic chk(input string nm, input logic [48:0] got, input logic [48:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  function automatic logic [48:0] mk(input logic [4:0] l, input logic [3:0] p, input logic [6:0] a, input logic [31:0] d);
    packet_t t;
    t = '{1'b1, l, p, a, d};
    return t;
  endfunction
  function automatic logic [31:0] dw(input int s, input int r);
    return 32'hD000_0000 | (32'(s) << 20) | 32'(r);
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(input int s, input int l, input int p);
    vld = '0;
    cfg_wr_en = 1;
    cfg_stream = 4'(s);
    cfg_leaf = 5'(l);
    cfg_port = 4'(p);
    tick;
    cfg_wr_en = 0;
  endtask
  task automatic run(input int cycles, output int n);
    n = 0;
    vld = 3'b001;
    for (int c = 0; c < cycles; c++) begin
      din[31:0] = 32'(c);
      #1;
      if (ack[0]) n++;
      @(posedge clk);
      #1;
    end
    vld = '0;
  endtask
  initial begin
    int n;
    tab[0]  = '{3'b111, 1'b0, 3'b010, mk(7, 1, 0, dw(1, 0))};
    tab[1]  = '{3'b111, 1'b0, 3'b100, mk(31, 15, 0, dw(2, 1))};
    tab[2]  = '{3'b111, 1'b0, 3'b001, mk(5, 2, 2, dw(0, 2))};
    tab[3]  = '{3'b111, 1'b1, 3'b000, mk(5, 2, 2, dw(0, 2))};
    tab[4]  = '{3'b111, 1'b1, 3'b000, mk(5, 2, 2, dw(0, 2))};
    tab[5]  = '{3'b111, 1'b1, 3'b000, mk(5, 2, 2, dw(0, 2))};
    tab[6]  = '{3'b111, 1'b0, 3'b010, mk(7, 1, 1, dw(1, 6))};
    tab[7]  = '{3'b101, 1'b0, 3'b100, mk(31, 15, 1, dw(2, 7))};
    tab[8]  = '{3'b010, 1'b0, 3'b010, mk(7, 1, 2, dw(1, 8))};
    tab[9]  = '{3'b000, 1'b0, 3'b000, '0};
    tab[10] = '{3'b011, 1'b0, 3'b001, mk(5, 2, 3, dw(0, 10))};
    tab[11] = '{3'b110, 1'b0, 3'b010, mk(7, 1, 3, dw(1, 11))};
    tab[12] = '{3'b000, 1'b0, 3'b000, '0};
    tab[13] = '{3'b111, 1'b1, 3'b000, '0};
    tab[14] = '{3'b111, 1'b0, 3'b100, mk(31, 15, 2, dw(2, 14))};
    tick;
    tick;
    reset = 0;
    chk("reset_dout", dout, '0);
    chk("reset_ack", 49'(ack), '0);
    vld = 3'b111;
    #1 chk("unconfigured_ack", 49'(ack), '0);
    tick;
    chk("unconfigured_dout", dout, '0);
    cfg(0, 5, 2);
    vld = 3'b001;
    din[31:0] = 32'hDEADBEEF;
    #1 chk("pre_start_ack", 49'(ack), '0);
    tick;
    chk("pre_start_dout", dout, '0);
    ap_start = 1;
    #1 chk("start_cycle_ack", 49'(ack), '0);
    tick;
    chk("start_cycle_dout", dout, '0);
    ap_start = 0;
    #1 chk("first_ack", 49'(ack), 49'(3'b001));
    tick;
    chk("first_dout", dout, mk(5, 2, 0, 32'hDEADBEEF));
    din[31:0] = 32'h12345678;
    #1 chk("second_ack", 49'(ack), 49'(3'b001));
    tick;
    chk("second_dout", dout, mk(5, 2, 1, 32'h12345678));
    vld = 3'b010;
    #1 chk("unconf_s1_ack", 49'(ack), '0);
    tick;
    chk("unconf_s1_dout", dout, '0);
    cfg(1, 7, 1);
    cfg(2, 31, 15);
    cfg(6, 1, 1);
    for (int r = 0; r < 15; r++) begin
      vld = tab[r].vld;
      resend = tab[r].resend;
      for (int i = 0; i < 3; i++) din[i*32 +: 32] = dw(i, r);
      #1 chk($sformatf("row%0d_ack", r), 49'(ack), 49'(tab[r].ack));
      tick;
      chk($sformatf("row%0d_dout", r), dout, tab[r].dout);
    end
    resend = 0;
    vld = 3'b001;
    din[31:0] = 32'hAAAA0001;
    cfg_wr_en = 1;
    cfg_stream = 0;
    cfg_leaf = 9;
    cfg_port = 3;
    #1 chk("cfg_collide_ack", 49'(ack), 49'(3'b001));
    tick;
    chk("cfg_collide_dout", dout, mk(5, 2, 4, 32'hAAAA0001));
    cfg_wr_en = 0;
    din[31:0] = 32'hAAAA0002;
    #1;
    tick;
    chk("cfg_new_dest_dout", dout, mk(9, 3, 0, 32'hAAAA0002));
    vld = 3'b111;
    reset = 1;
    tick;
    chk("midreset_dout", dout, '0);
    reset = 0;
    #1 chk("post_reset_ack", 49'(ack), '0);
    tick;
    chk("post_reset_dout", dout, '0);
    cfg(0, 5, 2);
    ap_start = 1;
    tick;
    ap_start = 0;
`ifdef LEAF_TX_CREDIT_EN
    run(128, n);
    chk("credit_128_words", 49'(n), 49'd128);
    chk("credit_128_last", dout, mk(5, 2, 127, 127));
    run(5, n);
    chk("credit_exhausted", 49'(n), '0);
    vld = 3'b001;
    din[31:0] = 32'h0000BEEF;
    credit_vld = 1;
    credit_stream = 0;
    #1 chk("credit_update_cycle_ack", 49'(ack), '0);
    tick;
    credit_vld = 0;
    #1 chk("credit_reenable_ack", 49'(ack), 49'(3'b001));
    tick;
    chk("credit_wrap_dout", dout, mk(5, 2, 0, 32'h0000BEEF));
    run(100, n);
    chk("credit_64_more", 49'(n), 49'd63);
    cfg(0, 5, 2);
    run(28, n);
    vld = 3'b001;
    credit_vld = 1;
    #1 chk("sat_collide_ack", 49'(ack), 49'(3'b001));
    tick;
    credit_vld = 0;
    run(200, n);
    chk("credit_saturate_128", 49'(n), 49'd128);
    cfg(0, 5, 2);
    run(118, n);
    vld = 3'b001;
    credit_vld = 1;
    #1 chk("c10_collide_ack", 49'(ack), 49'(3'b001));
    tick;
    credit_vld = 0;
    run(200, n);
    chk("credit_10_to_73", 49'(n), 49'd73);
`else
    run(200, n);
    chk("nocredit_200_words", 49'(n), 49'd200);
    chk("nocredit_last_dout", dout, mk(5, 2, 71, 199));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
